// File: rtl/pmt_gated_counter_pkg.sv
// Shared types and constants for the PMT gated photon counter family.
package pmt_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_GATE_W = 24;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } pmt_state_e;

endpackage

// File: rtl/pmt_gated_counter_if.sv
// Control, pulse input and result handshake bundle of the PMT gated counter.
interface pmt_gated_counter_if #(
   parameter int WIDTH  = pmt_pkg::DEF_WIDTH,
   parameter int GATE_W = pmt_pkg::DEF_GATE_W
);
   logic              pmt_in;
   logic              start;
   logic [GATE_W-1:0] gate_len;
   logic              dir;
   logic              saturate;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic              busy;
   logic [WIDTH-1:0]  out_count;
   logic              overflow;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output pmt_in, start, gate_len, dir, saturate, load, load_val, out_ready,
      input  busy, out_count, overflow, out_valid
   );

   modport slave (
      input  pmt_in, start, gate_len, dir, saturate, load, load_val, out_ready,
      output busy, out_count, overflow, out_valid
   );
endinterface

// File: rtl/pmt_gated_counter_pulse_sync.sv
// Multi-flop synchroniser for an asynchronous PMT line followed by a rising-edge
// detector; o_pulse is high for one cycle per synchronised rise (SYNC_STAGES >= 2).
module pmt_pulse_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_pulse
);
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_d;

   // Synchroniser chain plus one delayed copy of its last stage for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync   <= {SYNC_STAGES{1'b0}};
         r_sync_d <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_sync_d <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/pmt_gated_counter.sv
// Gated PMT photon counter: counts synchronised pmt_in rises during a programmable
// window, up or down from a preset, and offers the result on valid/ready.
module pmt_gated_counter
   import pmt_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int GATE_W      = DEF_GATE_W,
   parameter int SYNC_STAGES = 2
) (
   input logic                clk,
   input logic                reset,
   pmt_gated_counter_if.slave pmt_bus
);
   localparam logic [WIDTH-1:0]  ACC_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]  ACC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]  ACC_MAX  = {WIDTH{1'b1}};
   localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
   localparam logic [GATE_W-1:0] GATE_ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

   pmt_state_e        r_state;
   logic [WIDTH-1:0]  r_preset;
   logic [WIDTH-1:0]  r_acc;
   logic [GATE_W-1:0] r_gate_cnt;
   logic              r_dir;
   logic              r_sat;
   logic [WIDTH-1:0]  r_out_count;
   logic              r_overflow;
   logic              r_out_valid;
   logic              r_busy;

   logic              w_pulse;
   logic [WIDTH-1:0]  w_acc_next;
   logic              w_bound;
   logic [WIDTH-1:0]  w_start_val;

   pmt_pulse_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pulse_sync (
      .clk     (clk),
      .reset   (reset),
      .i_async (pmt_bus.pmt_in),
      .o_pulse (w_pulse)
   );

   // A load in the same cycle as start takes effect as the window's start value.
   assign w_start_val = pmt_bus.load ? pmt_bus.load_val : r_preset;

   // One-step accumulator update with bound detection and clamp/wrap selection.
   always_comb begin
      w_acc_next = r_acc;
      w_bound    = 1'b0;
      if (!w_pulse) begin
         w_acc_next = r_acc;
      end else if (r_dir == DIR_UP) begin
         if (r_acc == ACC_MAX) begin
            w_bound    = 1'b1;
            w_acc_next = r_sat ? ACC_MAX : ACC_ZERO;
         end else begin
            w_acc_next = r_acc + ACC_ONE;
         end
      end else begin
         if (r_acc == ACC_ZERO) begin
            w_bound    = 1'b1;
            w_acc_next = r_sat ? ACC_ZERO : ACC_MAX;
         end else begin
            w_acc_next = r_acc - ACC_ONE;
         end
      end
   end

   // Window control FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_preset    <= ACC_ZERO;
         r_acc       <= ACC_ZERO;
         r_gate_cnt  <= GATE_ZERO;
         r_dir       <= DIR_UP;
         r_sat       <= 1'b0;
         r_out_count <= ACC_ZERO;
         r_overflow  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (pmt_bus.load) begin
                  r_preset <= pmt_bus.load_val;
               end
               if (pmt_bus.start) begin
                  r_overflow <= 1'b0;
                  r_busy     <= 1'b1;
                  if (pmt_bus.gate_len != GATE_ZERO) begin
                     r_acc      <= w_start_val;
                     r_gate_cnt <= pmt_bus.gate_len;
                     r_dir      <= pmt_bus.dir;
                     r_sat      <= pmt_bus.saturate;
                     r_state    <= COUNT;
                  end else begin
                     r_out_count <= w_start_val;
                     r_out_valid <= 1'b1;
                     r_state     <= HOLD;
                  end
               end
            end
            COUNT: begin
               r_acc      <= w_acc_next;
               r_gate_cnt <= r_gate_cnt - GATE_ONE;
               if (w_bound) begin
                  r_overflow <= 1'b1;
               end
               // Last gate cycle: its pulse is folded into the latched result.
               if (r_gate_cnt == GATE_ONE) begin
                  r_out_count <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end
            end
            HOLD: begin
               if (pmt_bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign pmt_bus.busy      = r_busy;
   assign pmt_bus.out_count = r_out_count;
   assign pmt_bus.overflow  = r_overflow;
   assign pmt_bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_pmt_gated_counter.sv
// Randomised + directed bench for pmt_gated_counter: a 16-bit and a 4-bit build
// share one stimulus stream and are checked every cycle against a window-level model.
module tb_pmt_gated_counter;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        t_reset = 1'b1;
   logic        t_pmt = 1'b0, t_start = 1'b0, t_dir = 1'b0, t_sat = 1'b0;
   logic        t_load = 1'b0, t_ready = 1'b0;
   logic [23:0] t_gate = 24'd0;
   logic [15:0] t_load_val = 16'd0;

   pmt_gated_counter_if #(.WIDTH(16), .GATE_W(24)) if16 ();
   pmt_gated_counter_if #(.WIDTH(4),  .GATE_W(24)) if4 ();

   assign if16.pmt_in = t_pmt;    assign if4.pmt_in = t_pmt;
   assign if16.start = t_start;   assign if4.start = t_start;
   assign if16.gate_len = t_gate; assign if4.gate_len = t_gate;
   assign if16.dir = t_dir;       assign if4.dir = t_dir;
   assign if16.saturate = t_sat;  assign if4.saturate = t_sat;
   assign if16.load = t_load;     assign if4.load = t_load;
   assign if16.load_val = t_load_val;
   assign if4.load_val = t_load_val[3:0];
   assign if16.out_ready = t_ready;
   assign if4.out_ready = t_ready;

   pmt_gated_counter #(.WIDTH(16), .GATE_W(24), .SYNC_STAGES(SYNC)) dut16 (
      .clk(clk), .reset(t_reset), .pmt_bus(if16.slave));
   pmt_gated_counter #(.WIDTH(4), .GATE_W(24), .SYNC_STAGES(SYNC)) dut4 (
      .clk(clk), .reset(t_reset), .pmt_bus(if4.slave));

   int n_checks = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Window-level model: remaining gate cycles, hold flag, accumulators per width.
   int m_rem = 0;
   bit m_hold = 1'b0;
   int m_preset = 0;
   bit m_dir = 1'b0, m_sat = 1'b0;
   int m_acc16 = 0, m_acc4 = 0, m_oc16 = 0, m_oc4 = 0;
   bit m_ovf16 = 1'b0, m_ovf4 = 1'b0;
   bit hist [0:SYNC];   // hist[k] = pmt_in sampled k+1 edges ago

   task automatic check(input string nm, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic bump(input int maxv, input bit dn, input bit sat, input int a_in,
                       output int a_out, output bit hit);
      hit = 1'b0;
      a_out = a_in;
      if (!dn) begin
         if (a_in == maxv) begin hit = 1'b1; a_out = sat ? maxv : 0; end
         else a_out = a_in + 1;
      end else begin
         if (a_in == 0) begin hit = 1'b1; a_out = sat ? 0 : maxv; end
         else a_out = a_in - 1;
      end
   endtask

   task automatic model_step();
      bit pulse;
      int sv, a;
      bit h;
      pulse = hist[SYNC-1] && !hist[SYNC];
      if (t_reset) begin
         m_rem = 0; m_hold = 1'b0; m_preset = 0; m_acc16 = 0; m_acc4 = 0;
         m_oc16 = 0; m_oc4 = 0; m_ovf16 = 1'b0; m_ovf4 = 1'b0;
      end else if (m_rem > 0) begin
         if (pulse) begin
            bump(65535, m_dir, m_sat, m_acc16, a, h); m_acc16 = a; if (h) m_ovf16 = 1'b1;
            bump(15, m_dir, m_sat, m_acc4, a, h);     m_acc4 = a;  if (h) m_ovf4 = 1'b1;
         end
         m_rem--;
         if (m_rem == 0) begin m_hold = 1'b1; m_oc16 = m_acc16; m_oc4 = m_acc4; end
      end else if (m_hold) begin
         if (t_ready) m_hold = 1'b0;
      end else begin
         sv = t_load ? int'(t_load_val) : m_preset;
         if (t_load) m_preset = int'(t_load_val);
         if (t_start) begin
            m_ovf16 = 1'b0; m_ovf4 = 1'b0;
            if (t_gate != 24'd0) begin
               m_rem = int'(t_gate); m_acc16 = sv; m_acc4 = sv % 16;
               m_dir = t_dir; m_sat = t_sat;
            end else begin
               m_hold = 1'b1; m_oc16 = sv; m_oc4 = sv % 16;
            end
         end
      end
      for (int k = SYNC; k > 0; k--) hist[k] = t_reset ? 1'b0 : hist[k-1];
      hist[0] = t_reset ? 1'b0 : t_pmt;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   // Every-cycle comparison of both builds against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy16", 32'(if16.busy), int'((m_rem > 0) || m_hold));
         check("valid16", 32'(if16.out_valid), int'(m_hold));
         check("count16", 32'(if16.out_count), m_oc16);
         check("ovf16", 32'(if16.overflow), int'(m_ovf16));
         check("busy4", 32'(if4.busy), int'((m_rem > 0) || m_hold));
         check("valid4", 32'(if4.out_valid), int'(m_hold));
         check("count4", 32'(if4.out_count), m_oc4);
         check("ovf4", 32'(if4.overflow), int'(m_ovf4));
      end
   end

   task automatic wait_valid(input string nm);
      int n = 0;
      while (if16.out_valid !== 1'b1 && n < 50) begin tick(); n++; end
      check({nm, "_valid_seen"}, 32'(if16.out_valid), 1);
   endtask

   task automatic accept();
      t_ready = 1'b1; tick(); t_ready = 1'b0; tick();
   endtask

   // Preset write, start, then pmt activity for the whole gate; ends in HOLD.
   task automatic window(input logic [15:0] lv, input bit d, input bit s,
                         input int g, input int np, input bit level_hi);
      t_load = 1'b1; t_load_val = lv; tick(); t_load = 1'b0;
      t_start = 1'b1; t_gate = 24'(g); t_dir = d; t_sat = s; tick();
      t_start = 1'b0; t_dir = ~d; t_sat = ~s;
      for (int i = 0; i < g; i++) begin
         t_pmt = level_hi ? 1'b1 : ((i < 2*np) && (i % 2 == 0));
         tick();
      end
      t_pmt = 1'b0;
      wait_valid("win");
   endtask

   initial begin
      for (int k = 0; k <= SYNC; k++) hist[k] = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      check("rst_busy", 32'(if16.busy), 0);
      check("rst_count", 32'(if16.out_count), 0);
      t_reset = 1'b0;
      tick();

      window(16'd0, 1'b0, 1'b0, 10, 4, 1'b0);
      check("s1_count16", 32'(if16.out_count), 4);
      check("s1_ovf16", 32'(if16.overflow), 0);
      accept();

      window(16'd3, 1'b1, 1'b1, 20, 6, 1'b0);
      check("s2_count16", 32'(if16.out_count), 0);
      check("s2_ovf16", 32'(if16.overflow), 1);
      accept();

      window(16'd14, 1'b0, 1'b0, 10, 3, 1'b0);
      check("s3_count4", 32'(if4.out_count), 1);
      check("s3_ovf4", 32'(if4.overflow), 1);
      check("s3_count16", 32'(if16.out_count), 17);
      accept();

      window(16'd14, 1'b0, 1'b1, 10, 3, 1'b0);
      check("s4_count4", 32'(if4.out_count), 15);
      check("s4_ovf4", 32'(if4.overflow), 1);
      accept();

      // Zero-length gate, then HOLD with ready low and start/load ignored.
      t_load = 1'b1; t_load_val = 16'd7; tick(); t_load = 1'b0;
      t_start = 1'b1; t_gate = 24'd0; tick(); t_start = 1'b0;
      check("s5_valid", 32'(if16.out_valid), 1);
      check("s5_count", 32'(if16.out_count), 7);
      check("s5_ovf", 32'(if16.overflow), 0);
      for (int i = 0; i < 5; i++) begin
         t_start = (i % 2 == 0); t_gate = 24'd5; t_load = (i % 2 == 1); t_load_val = 16'd99;
         tick();
         check("s6_stable", 32'(if16.out_count), 7);
      end
      t_start = 1'b0; t_load = 1'b0;
      accept();
      check("s6_idle", 32'(if16.busy), 0);
      t_start = 1'b1; t_gate = 24'd0; tick(); t_start = 1'b0;
      check("s6_preset_kept", 32'(if16.out_count), 7);
      accept();

      t_load = 1'b1; t_load_val = 16'd9; t_start = 1'b1; t_gate = 24'd0; tick();
      t_load = 1'b0; t_start = 1'b0;
      check("load_start_count", 32'(if16.out_count), 9);
      accept();

      // Reset in the middle of a window.
      t_start = 1'b1; t_gate = 24'd20; t_dir = 1'b0; tick(); t_start = 1'b0;
      for (int i = 0; i < 6; i++) begin t_pmt = (i % 2 == 0); tick(); end
      t_pmt = 1'b0; t_reset = 1'b1; tick(); t_reset = 1'b0;
      check("s7_busy", 32'(if16.busy), 0);
      check("s7_valid", 32'(if16.out_valid), 0);
      check("s7_count", 32'(if16.out_count), 0);
      repeat (25) tick();
      check("s7_no_valid", 32'(if16.out_valid), 0);

      window(16'd0, 1'b0, 1'b0, 10, 0, 1'b1);
      check("s8_level_once", 32'(if16.out_count), 1);
      accept();

      // Randomised phase, biased towards the bounds of both widths.
      for (int c = 0; c < 4000; c++) begin
         t_reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 2) == 0) t_pmt = ~t_pmt;
         t_start = ($urandom_range(0, 5) == 0);
         t_gate = 24'($urandom_range(0, 14));
         t_dir = 1'($urandom_range(0, 1));
         t_sat = 1'($urandom_range(0, 1));
         t_load = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 4))
            0: t_load_val = 16'hFFFF;
            1: t_load_val = 16'hFFFE;
            2: t_load_val = 16'h0001;
            3: t_load_val = 16'($urandom_range(12, 17));
            default: t_load_val = 16'($urandom);
         endcase
         t_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      t_reset = 1'b0; t_start = 1'b0; t_load = 1'b0; t_ready = 1'b1;
      repeat (20) tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
